// File: rtl/dmem_arbiter_if.sv
// Request/response channel between one master and the data-memory arbiter.
// The arbiter takes the slave side; each requester takes the master side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Master 0 is the load/store unit, master 1 the debug/DMA port. One access
// is in flight at a time: IDLE -> ACCESS (-> RESP for reads) -> IDLE.
// Build option ARB_RR_EN: round-robin between the masters on simultaneous
// requests; when undefined, master 0 has fixed priority and master 1 may starve.
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              owner;     // master holding the memory: 0 or 1
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              any_req;
  logic              sel;       // master that wins if the memory is free

`ifdef ARB_RR_EN
  logic prio;                   // master preferred on the next tie
`endif

  assign m0.gnt    = gnt_q[0];
  assign m1.gnt    = gnt_q[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

  // Pick the winner among the current requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    any_req = m0.req | m1.req;
    sel     = 1'b0;
`ifdef ARB_RR_EN
    if (m0.req && m1.req) sel = prio;
    else                  sel = m1.req;
`else
    sel = ~m0.req;
`endif
  end

  // Sequencer: capture a request, run one memory cycle, return read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      gnt_q     <= 2'b00;
      rvalid_q  <= 2'b00;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
`ifdef ARB_RR_EN
      prio      <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner       <= sel;
            gnt_q[sel]  <= 1'b1;
            mem_addr    <= sel ? m1.addr  : m0.addr;
            mem_wdata   <= sel ? m1.wdata : m0.wdata;
            mem_we      <= sel ? m1.we    : m0.we;
            mem_re      <= sel ? ~m1.we   : ~m0.we;
            state       <= ACCESS;
`ifdef ARB_RR_EN
            prio        <= ~sel;
`endif
          end
        end
        ACCESS: begin
          // mem_we still holds the captured direction during this cycle.
          if (mem_we) begin
            state <= IDLE;
          end else begin
            if (owner) rdata1 <= mem_rdata;
            else       rdata0 <= mem_rdata;
            rvalid_q[owner] <= 1'b1;
            state           <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
